// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the decode-control stage
package decode_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_SYSTEM = 7'b1110011,
        OP_FENCE  = 7'b0001111
    } opcode_e;

    localparam logic [1:0] ALU_OP_LOAD_STORE = 2'b00;
    localparam logic [1:0] ALU_OP_I_TYPE     = 2'b01;
    localparam logic [1:0] ALU_OP_B_TYPE     = 2'b10;
    localparam logic [1:0] ALU_OP_R_TYPE     = 2'b11;

    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_MRET   = 12'h302;
    localparam logic [11:0] F12_WFI    = 12'h105;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       jump;
        logic [1:0] alu_op;
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       r_type;
        logic       muldiv;
        logic       csr_write;
        logic       csr_data_sel;
        logic       csr_to_reg;
        logic       is_csr;
        logic       is_mret;
        logic       is_ecall;
        logic       is_ebreak;
        logic       is_wfi;
        logic       is_fence;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } dec_state_e;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I/M/Zicsr instruction to control-bundle decoder
module decode_comb
    import decode_pkg::*;
#(
    parameter bit SUPPORT_M   = 1'b1,
    parameter bit SUPPORT_CSR = 1'b1,
    parameter bit SUPPORT_WFI = 1'b1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] f12;
    logic        ill;

    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign rd  = instr_i[11:7];
    assign rs1 = instr_i[19:15];
    assign f12 = instr_i[31:20];

    // Decode by opcode class, then squash all architectural side effects if illegal
    always_comb begin
        ctrl_o = '0;
        ill    = 1'b0;
        case (opcode_e'(instr_i[6:0]))
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.r_type    = 1'b1;
                ctrl_o.alu_op    = ALU_OP_R_TYPE;
                if (f7 == 7'b0000001) begin
                    if (SUPPORT_M) ctrl_o.muldiv = 1'b1;
                    else           ill = 1'b1;
                end else if (f7 == 7'b0100000) begin
                    // Only SUB and SRA use the alternate funct7
                    ill = !((f3 == 3'b000) || (f3 == 3'b101));
                end else if (f7 != 7'b0000000) begin
                    ill = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_I_TYPE;
                if (f3 == 3'b001)      ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101) ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
            end
            OP_JALR: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.jump      = 1'b1;
                ill = (f3 != 3'b000);
            end
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ill = f3 inside {3'b011, 3'b110, 3'b111};
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ill = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_OP_B_TYPE;
                ill = f3 inside {3'b010, 3'b011};
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.jal       = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.lui       = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.auipc     = 1'b1;
            end
            OP_FENCE: begin
                ctrl_o.is_fence = 1'b1;
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    // Privileged ops require rd and rs1 both x0
                    if ((rd != 5'd0) || (rs1 != 5'd0)) begin
                        ill = 1'b1;
                    end else begin
                        case (f12)
                            F12_ECALL:  ctrl_o.is_ecall  = 1'b1;
                            F12_EBREAK: ctrl_o.is_ebreak = 1'b1;
                            F12_MRET:   ctrl_o.is_mret   = 1'b1;
                            F12_WFI:    ctrl_o.is_wfi    = SUPPORT_WFI;
                            default:    ill = 1'b1;
                        endcase
                    end
                end else if ((f3 == 3'b100) || !SUPPORT_CSR) begin
                    ill = 1'b1;
                end else begin
                    ctrl_o.is_csr       = 1'b1;
                    ctrl_o.csr_to_reg   = 1'b1;
                    ctrl_o.csr_data_sel = f3[2];
                    ctrl_o.reg_write    = (rd != 5'd0);
                    // Set/clear forms with a zero source must not write the CSR
                    ctrl_o.csr_write    = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctrl_o.reg_write = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.csr_write = 1'b0;
            ctrl_o.branch    = 1'b0;
            ctrl_o.jump      = 1'b0;
            ctrl_o.muldiv    = 1'b0;
            ctrl_o.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered decode stage with valid/ready handshake, flush and WFI sleep
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter bit SUPPORT_M   = 1'b1,
    parameter bit SUPPORT_CSR = 1'b1,
    parameter bit SUPPORT_WFI = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    input  logic        irq_pending,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output ctrl_t       out_ctrl,
    output logic        wfi_sleep
);

    dec_state_e  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, instr_q;
    ctrl_t       ctrl_q, ctrl_dec;
    logic        accept, transfer;

    decode_comb #(
        .SUPPORT_M   (SUPPORT_M),
        .SUPPORT_CSR (SUPPORT_CSR),
        .SUPPORT_WFI (SUPPORT_WFI)
    ) u_decode_comb (
        .instr_i (instr),
        .ctrl_o  (ctrl_dec)
    );

    assign accept   = in_valid & in_ready;
    assign transfer = valid_q & out_ready;

    // Sleep FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Sleep FSM next state: a WFI leaving the stage puts the core to sleep
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!flush && transfer && ctrl_q.is_wfi) state_d = SLEEP;
            SLEEP:   if (irq_pending || flush)                state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Sleep FSM outputs: stall the front end while asleep or backpressured
    always_comb begin
        wfi_sleep = (state_q == SLEEP);
        in_ready  = (state_q == RUN) & (~valid_q | out_ready) & ~flush;
    end

    // Output valid next state: flush kills, accept fills, consumption empties
    always_comb begin
        valid_d = valid_q;
        if (flush)         valid_d = 1'b0;
        else if (accept)   valid_d = 1'b1;
        else if (transfer) valid_d = 1'b0;
    end

    // Pipeline register; payload only moves on an accepted instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                pc_q    <= in_pc;
                instr_q <= instr;
                ctrl_q  <= ctrl_dec;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_ctrl  = ctrl_q;

endmodule
